session_controller: RTL

- Run-control sequencer for the trading datapath: decides when order generation and trade counting are live, paces the order stream with a slow tick, and trips a spread circuit breaker.
- Sits between the board buttons and the order_generator / counter pair.
- Exports its state and breaker status to vga_display for on-screen session status.

---
 rtl/session_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/session_controller.sv
// Purpose : run-control sequencer; gates order generation / trade counting, paces orders, trips a spread breaker.
// Latency : every output is registered; a button edge or halt changes the outputs on the following cycle.
// Backpres: none; halt_signal from the counter forces HALTED, and stop_btn overrides everything.
// Ports   : clk, reset (async, active-low), start_btn/stop_btn (rising edge acts), match_siganl (unused),
//           spread[7:0], halt_signal -> gen_enable, count_enable, count_clear (1-cycle pulse),
//           order_tick (1-cycle pulse), state[2:0], cooldown_left[7:0], breaker_trips[7:0] (saturating).
module session_controller #(
   parameter int unsigned TICK_DIV       = 1250000,
   parameter logic [7:0]  SPREAD_LIMIT   = 8'd200,
   parameter int unsigned BREACH_TICKS   = 4,
   parameter int unsigned COOLDOWN_TICKS = 40,
   parameter int unsigned SESSION_TICKS  = 1200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       match_siganl,
   input  logic [7:0] spread,
   input  logic       halt_signal,
   output logic       gen_enable,
   output logic       count_enable,
   output logic       count_clear,
   output logic       order_tick,
   output logic [2:0] state,
   output logic [7:0] cooldown_left,
   output logic [7:0] breaker_trips
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRE_OPEN = 3'd1;
   localparam logic [2:0] S_OPEN     = 3'd2;
   localparam logic [2:0] S_BREAKER  = 3'd3;
   localparam logic [2:0] S_HALTED   = 3'd4;
   localparam logic [2:0] S_CLOSED   = 3'd5;

   localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
   localparam logic [3:0]  BREACH_LIM = 4'(BREACH_TICKS);
   localparam logic [7:0]  COOL_INIT  = 8'(COOLDOWN_TICKS);
   localparam logic [15:0] SESS_LIM   = 16'(SESSION_TICKS);

   // The match flag is purely informational for this block.
   logic unused_match;
   assign unused_match = match_siganl;

   logic [2:0]  state_q, state_d;
   logic [23:0] presc_q, presc_d;
   logic        tick_q, tick_d;
   logic [15:0] sess_q, sess_d;
   logic [3:0]  breach_q, breach_d;
   logic [7:0]  cool_q, cool_d;
   logic [7:0]  trips_q, trips_d;
   logic        start_q, stop_q;
   logic        gen_q, gen_d;
   logic        cnt_en_q, cnt_en_d;
   logic        clr_q, clr_d;

   logic        start_ev, stop_ev;
   logic [15:0] sess_inc;
   logic [3:0]  breach_inc;
   logic        live_now, live_next;

   assign start_ev   = start_btn & ~start_q;
   assign stop_ev    = stop_btn & ~stop_q;
   assign sess_inc   = sess_q + 16'd1;
   assign breach_inc = (spread > SPREAD_LIMIT) ? breach_q + 4'd1 : 4'd0;

   // tick_q is the registered order_tick: the cycle in which the pulse is
   // visible is the cycle whose closing edge applies the tick's effects, so
   // spread is sampled exactly while order_tick is high.
   always_comb begin
      state_d  = state_q;
      sess_d   = sess_q;
      breach_d = breach_q;
      cool_d   = cool_q;
      trips_d  = trips_q;

      if (stop_ev) begin
         state_d  = S_IDLE;
         cool_d   = 8'd0;
         breach_d = 4'd0;
      end else begin
         case (state_q)
            S_IDLE, S_HALTED, S_CLOSED: begin
               if (start_ev) state_d = S_PRE_OPEN;
            end
            S_PRE_OPEN: begin
               state_d  = S_OPEN;
               sess_d   = 16'd0;
               breach_d = 4'd0;
            end
            S_OPEN: begin
               if (halt_signal) begin
                  state_d = S_HALTED;
               end else if (tick_q) begin
                  sess_d   = sess_inc;
                  breach_d = breach_inc;
                  // Session end outranks a trip landing on the same tick.
                  if (sess_inc == SESS_LIM) begin
                     state_d = S_CLOSED;
                  end else if (breach_inc == BREACH_LIM) begin
                     state_d = S_BREAKER;
                     cool_d  = COOL_INIT;
                     if (trips_q != 8'hFF) trips_d = trips_q + 8'd1;
                  end
               end
            end
            S_BREAKER: begin
               if (tick_q) begin
                  cool_d = cool_q - 8'd1;
                  if (cool_q == 8'd1) begin
                     state_d  = S_OPEN;
                     breach_d = 4'd0;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // The prescaler only runs while staying within OPEN/BREAKER; any entry
   // from or exit to another state restarts it at zero with no pulse.
   assign live_now  = (state_q == S_OPEN) || (state_q == S_BREAKER);
   assign live_next = (state_d == S_OPEN) || (state_d == S_BREAKER);

   always_comb begin
      presc_d = 24'd0;
      tick_d  = 1'b0;
      if (live_now && live_next) begin
         if (presc_q == TICK_LAST) begin
            tick_d = 1'b1;
         end else begin
            presc_d = presc_q + 24'd1;
         end
      end
   end

   assign gen_d    = (state_d == S_OPEN);
   assign cnt_en_d = (state_d == S_OPEN);
   assign clr_d    = (state_d == S_PRE_OPEN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         presc_q  <= 24'd0;
         tick_q   <= 1'b0;
         sess_q   <= 16'd0;
         breach_q <= 4'd0;
         cool_q   <= 8'd0;
         trips_q  <= 8'd0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         gen_q    <= 1'b0;
         cnt_en_q <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         sess_q   <= sess_d;
         breach_q <= breach_d;
         cool_q   <= cool_d;
         trips_q  <= trips_d;
         start_q  <= start_btn;
         stop_q   <= stop_btn;
         gen_q    <= gen_d;
         cnt_en_q <= cnt_en_d;
         clr_q    <= clr_d;
      end
   end

   assign gen_enable    = gen_q;
   assign count_enable  = cnt_en_q;
   assign count_clear   = clr_q;
   assign order_tick    = tick_q;
   assign state         = state_q;
   assign cooldown_left = cool_q;
   assign breaker_trips = trips_q;

endmodule
